// File: rtl/bj_auto_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bj_auto_player_pkg
// Brief    : Shared FSM encodings, blackjack limits and button levels for the
//            scripted BlackJack player.
// Revision : 1.0 - initial release
// ============================================================================
package bj_auto_player_pkg;

    localparam int   c_HAND_W     = 5;
    localparam int   c_BUST_LIMIT = 21;
    localparam logic c_BTN_ACTIVE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DECIDE     = 3'd1,
        ST_PRESS      = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_WAIT_READY = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    typedef enum logic {
        SEL_HIT  = 1'b0,
        SEL_STAY = 1'b1
    } sel_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bj_auto_player_if.sv
`default_nettype none
// ============================================================================
// Module   : bj_auto_player_if
// Brief    : Core-facing signal bundle of the scripted player; master is the
//            player, slave is the BlackJack core side.
// Revision : 1.0 - initial release
// ============================================================================
interface bj_auto_player_if
    import bj_auto_player_pkg::*;
#(
    parameter int HAND_W = c_HAND_W
) ();

    logic              i_Enable;
    logic              i_TurnActive;
    logic              i_Ready;
    logic [HAND_W-1:0] i_HandTotal;
    logic              o_Hit_n;
    logic              o_Stay_n;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Bust;
    logic              o_Timeout;
    logic [3:0]        o_HitCount;

    modport master (
        input  i_Enable, i_TurnActive, i_Ready, i_HandTotal,
        output o_Hit_n, o_Stay_n, o_Busy, o_Done, o_Bust, o_Timeout, o_HitCount
    );

    modport slave (
        output i_Enable, i_TurnActive, i_Ready, i_HandTotal,
        input  o_Hit_n, o_Stay_n, o_Busy, o_Done, o_Bust, o_Timeout, o_HitCount
    );

endinterface
`default_nettype wire

// File: rtl/bj_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : bj_cycle_timer
// Brief    : Loadable down-counter; expired while the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
module bj_cycle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/bj_auto_player.sv
`default_nettype none
// ============================================================================
// Module   : bj_auto_player
// Brief    : Scripted player driving the core's active-low Hit/Stay buttons
//            with a hit-below-threshold strategy. Optional WAIT_READY timeout
//            is built when BJ_AUTOPLAY_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module bj_auto_player
    import bj_auto_player_pkg::*;
#(
    parameter int HAND_W         = c_HAND_W,
    parameter int HIT_THRESHOLD  = 17,
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int MAX_HITS       = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    bj_auto_player_if.master bus
);

`ifdef BJ_AUTOPLAY_TIMEOUT_EN
    localparam int c_TMR_MAX = maxInt(maxInt(HOLD_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
    localparam int c_TMR_MAX = maxInt(HOLD_CYCLES, GAP_CYCLES);
`endif
    localparam int c_TMR_W = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [HAND_W-1:0] c_BUST      = HAND_W'(c_BUST_LIMIT);
    localparam logic [HAND_W-1:0] c_THRESHOLD = HAND_W'(HIT_THRESHOLD);
    localparam logic [3:0]        c_MAX_HITS  = 4'(MAX_HITS);

    generate
        if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_badParams
            $error("bj_auto_player: cycle counts must be at least 1");
        end
    endgenerate

    state_t               r_state, w_nextState;
    sel_t                 r_sel, w_nextSel;
    logic                 r_hitN, r_stayN, r_busy, r_done, r_bust;
    logic [3:0]           r_hitCount;
    logic                 w_active, w_setBust, w_incHit;
    logic                 w_timerLoad, w_timerExpired;
    logic [c_TMR_W-1:0]   w_timerValue;
`ifdef BJ_AUTOPLAY_TIMEOUT_EN
    logic                 r_timeout, w_setTimeout;
`endif

    bj_cycle_timer #(
        .WIDTH(c_TMR_W)
    ) u_timer (
        .clk        (i_Clk),
        .rst        (i_Reset),
        .i_load     (w_timerLoad),
        .i_loadValue(w_timerValue),
        .o_expired  (w_timerExpired)
    );

    assign w_active = bus.i_Enable && bus.i_TurnActive;

    always_comb begin
        w_nextState  = r_state;
        w_nextSel    = r_sel;
        w_timerLoad  = 1'b0;
        w_timerValue = '0;
        w_setBust    = 1'b0;
        w_incHit     = 1'b0;
`ifdef BJ_AUTOPLAY_TIMEOUT_EN
        w_setTimeout = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_active) w_nextState = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (!w_active) begin
                    w_nextState = ST_IDLE;
                end else if (bus.i_HandTotal > c_BUST) begin
                    w_nextState = ST_DONE;
                    w_setBust   = 1'b1;
                end else begin
                    w_nextSel    = (bus.i_HandTotal < c_THRESHOLD && r_hitCount < c_MAX_HITS)
                                   ? SEL_HIT : SEL_STAY;
                    w_nextState  = ST_PRESS;
                    w_timerLoad  = 1'b1;
                    w_timerValue = c_TMR_W'(HOLD_CYCLES - 1);
                end
            end
            ST_PRESS: begin
                if (!w_active) begin
                    w_nextState = ST_IDLE;
                end else if (w_timerExpired) begin
                    w_nextState  = ST_RELEASE;
                    w_timerLoad  = 1'b1;
                    w_timerValue = c_TMR_W'(GAP_CYCLES - 1);
                    w_incHit     = (r_sel == SEL_HIT);
                end
            end
            ST_RELEASE: begin
                if (!w_active) begin
                    w_nextState = ST_IDLE;
                end else if (w_timerExpired) begin
                    if (r_sel == SEL_HIT) begin
                        w_nextState = ST_WAIT_READY;
`ifdef BJ_AUTOPLAY_TIMEOUT_EN
                        w_timerLoad  = 1'b1;
                        w_timerValue = c_TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_WAIT_READY: begin
                if (!w_active) begin
                    w_nextState = ST_IDLE;
                end else if (bus.i_Ready) begin
                    w_nextState = ST_DECIDE;
`ifdef BJ_AUTOPLAY_TIMEOUT_EN
                end else if (w_timerExpired) begin
                    w_nextState  = ST_DONE;
                    w_setTimeout = 1'b1;
`endif
                end
            end
            ST_DONE: begin
                if (!w_active) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so buttons track the FSM edge-exactly.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_HIT;
            r_hitN     <= ~c_BTN_ACTIVE;
            r_stayN    <= ~c_BTN_ACTIVE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bust     <= 1'b0;
            r_hitCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_sel   <= w_nextSel;
            r_hitN  <= (w_nextState == ST_PRESS && w_nextSel == SEL_HIT)
                       ? c_BTN_ACTIVE : ~c_BTN_ACTIVE;
            r_stayN <= (w_nextState == ST_PRESS && w_nextSel == SEL_STAY)
                       ? c_BTN_ACTIVE : ~c_BTN_ACTIVE;
            r_busy  <= (w_nextState != ST_IDLE) && (w_nextState != ST_DONE);
            r_done  <= (w_nextState == ST_DONE);
            if (w_nextState == ST_IDLE) begin
                r_bust     <= 1'b0;
                r_hitCount <= '0;
            end else begin
                if (w_setBust) r_bust <= 1'b1;
                if (w_incHit && r_hitCount != c_MAX_HITS) r_hitCount <= r_hitCount + 4'd1;
            end
        end
    end

`ifdef BJ_AUTOPLAY_TIMEOUT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset || w_nextState == ST_IDLE) begin
            r_timeout <= 1'b0;
        end else if (w_setTimeout) begin
            r_timeout <= 1'b1;
        end
    end
    assign bus.o_Timeout = r_timeout;
`else
    assign bus.o_Timeout = 1'b0;
`endif

    assign bus.o_Hit_n    = r_hitN;
    assign bus.o_Stay_n   = r_stayN;
    assign bus.o_Busy     = r_busy;
    assign bus.o_Done     = r_done;
    assign bus.o_Bust     = r_bust;
    assign bus.o_HitCount = r_hitCount;

endmodule
`default_nettype wire

// File: tb/tb_bj_auto_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_bj_auto_player
// Brief    : Self-checking bench for bj_auto_player; button presses are scored
//            against an expected-press queue, flags checked inline per test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bj_auto_player;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bj_auto_player_if #(.HAND_W(5)) bus ();

    bj_auto_player #(
        .HAND_W        (5),
        .HIT_THRESHOLD (17),
        .HOLD_CYCLES   (4),
        .GAP_CYCLES    (4),
        .MAX_HITS      (11),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    // {hit_n, stay_n, busy, done, bust, timeout, hitcount[3:0]}
    wire [9:0] obs = {bus.o_Hit_n, bus.o_Stay_n, bus.o_Busy, bus.o_Done,
                      bus.o_Bust, bus.o_Timeout, bus.o_HitCount};

    typedef struct {
        bit isHit;
        int start;
        int len;
    } press_t;

    press_t expQ[$];
    press_t e;
    int nChecks = 0;
    int nPass   = 0;

    logic [1:0] prevBtn = 2'b11;
    int pStart[2];

    // Press monitor: scores every completed press against the expected queue.
    always @(negedge clk) begin
        logic [1:0] btn;
        btn = {bus.o_Stay_n, bus.o_Hit_n};
        nChecks++;
        if (btn === 2'b00) $display("FAIL both_low: cycle %0d buttons=%b, required never 00", cyc, btn);
        else nPass++;
        for (int b = 0; b < 2; b++) begin
            if (btn[b] === 1'b0 && prevBtn[b] === 1'b1) pStart[b] = cyc;
            if (btn[b] === 1'b1 && prevBtn[b] === 1'b0) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    $display("FAIL press_unexpected: hit=%0d start=%0d len=%0d, required no press",
                             (b == 0), pStart[b], cyc - pStart[b]);
                end else begin
                    e = expQ.pop_front();
                    if (e.isHit !== (b == 0) || e.start !== pStart[b] || e.len !== cyc - pStart[b])
                        $display("FAIL press: got hit=%0d start=%0d len=%0d, required hit=%0d start=%0d len=%0d",
                                 (b == 0), pStart[b], cyc - pStart[b], e.isHit, e.start, e.len);
                    else nPass++;
                end
            end
        end
        prevBtn = btn;
    end

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic startTurn(input logic [4:0] total, output int s);
        s = cyc;
        bus.i_HandTotal  = total;
        bus.i_Enable     = 1'b1;
        bus.i_TurnActive = 1'b1;
    endtask

    task automatic endTurn();
        bus.i_Enable     = 1'b0;
        bus.i_TurnActive = 1'b0;
        @(negedge clk);
        nChecks++;
        if (obs !== 10'b11_0000_0000) $display("FAIL idle_after_turn: got %b, required 1100000000", obs);
        else nPass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nChecks++;
        if (obs !== 10'b11_0000_0000) $display("FAIL reset_state: got %b, required 1100000000", obs);
        else nPass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hit_then_stay();
        int s, r;
        startTurn(5'd12, s);
        expQ.push_back('{1'b1, s + 2, 4});
        waitUntil(s + 1);
        nChecks++;
        if (obs !== 10'b11_1000_0000) $display("FAIL hs_decide: got %b, required 1110000000", obs);
        else nPass++;
        waitUntil(s + 6);
        nChecks++;
        if (obs !== 10'b11_1000_0001) $display("FAIL hs_gap_count: got %b, required 1110000001", obs);
        else nPass++;
        waitUntil(s + 11);
        r = cyc;
        bus.i_HandTotal = 5'd18;
        bus.i_Ready     = 1'b1;
        expQ.push_back('{1'b0, r + 2, 4});
        waitUntil(r + 1);
        bus.i_Ready = 1'b0;
        waitUntil(r + 2);
        bus.i_HandTotal = 5'd5;
        waitUntil(r + 9);
        nChecks++;
        if (obs !== 10'b11_1000_0001) $display("FAIL hs_before_done: got %b, required 1110000001", obs);
        else nPass++;
        waitUntil(r + 10);
        nChecks++;
        if (obs !== 10'b11_0100_0001) $display("FAIL hs_done: got %b, required 1101000001", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_stay_threshold();
        int s;
        startTurn(5'd17, s);
        expQ.push_back('{1'b0, s + 2, 4});
        waitUntil(s + 10);
        nChecks++;
        if (obs !== 10'b11_0100_0000) $display("FAIL stay17_done: got %b, required 1101000000", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_hit_below();
        int s;
        startTurn(5'd16, s);
        expQ.push_back('{1'b1, s + 2, 4});
        waitUntil(s + 11);
        nChecks++;
        if (obs !== 10'b11_1000_0001) $display("FAIL hit16_wait: got %b, required 1110000001", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_bust();
        int s;
        startTurn(5'd23, s);
        waitUntil(s + 1);
        nChecks++;
        if (obs !== 10'b11_1000_0000) $display("FAIL bust_decide: got %b, required 1110000000", obs);
        else nPass++;
        waitUntil(s + 2);
        nChecks++;
        if (obs !== 10'b11_0110_0000) $display("FAIL bust_done: got %b, required 1101100000", obs);
        else nPass++;
        waitUntil(s + 5);
        nChecks++;
        if (obs !== 10'b11_0110_0000) $display("FAIL bust_hold: got %b, required 1101100000", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_enable_drop();
        int s;
        startTurn(5'd12, s);
        expQ.push_back('{1'b1, s + 2, 2});
        waitUntil(s + 3);
        nChecks++;
        if (obs !== 10'b01_1000_0000) $display("FAIL drop_pressing: got %b, required 0110000000", obs);
        else nPass++;
        bus.i_Enable = 1'b0;
        waitUntil(s + 4);
        nChecks++;
        if (obs !== 10'b11_0000_0000) $display("FAIL drop_idle: got %b, required 1100000000", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_reset_mid_press();
        int s, r;
        startTurn(5'd12, s);
        expQ.push_back('{1'b1, s + 2, 4});
        waitUntil(s + 11);
        r = cyc;
        bus.i_Ready = 1'b1;
        expQ.push_back('{1'b1, r + 2, 2});
        waitUntil(r + 1);
        bus.i_Ready = 1'b0;
        waitUntil(r + 3);
        nChecks++;
        if (obs !== 10'b01_1000_0001) $display("FAIL rstp_pressing: got %b, required 0110000001", obs);
        else nPass++;
        rst              = 1'b1;
        bus.i_Enable     = 1'b0;
        bus.i_TurnActive = 1'b0;
        waitUntil(r + 4);
        nChecks++;
        if (obs !== 10'b11_0000_0000) $display("FAIL rstp_first: got %b, required 1100000000", obs);
        else nPass++;
        waitUntil(r + 5);
        nChecks++;
        if (obs !== 10'b11_0000_0000) $display("FAIL rstp_second: got %b, required 1100000000", obs);
        else nPass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back_max_hits();
        int s, p;
        startTurn(5'd5, s);
        p = s + 2;
        for (int i = 0; i < 11; i++) begin
            expQ.push_back('{1'b1, p, 4});
            waitUntil(p + 8);
            nChecks++;
            if (obs !== {6'b11_1000, 4'(i + 1)})
                $display("FAIL maxhit_wait%0d: got %b, required %b", i, obs, {6'b11_1000, 4'(i + 1)});
            else nPass++;
            bus.i_Ready = 1'b1;
            waitUntil(p + 9);
            bus.i_Ready = 1'b0;
            p = p + 10;
        end
        expQ.push_back('{1'b0, p, 4});
        waitUntil(p + 8);
        nChecks++;
        if (obs !== 10'b11_0100_1011) $display("FAIL maxhit_done: got %b, required 1101001011", obs);
        else nPass++;
        endTurn();
    endtask

    task automatic test_timeout();
        int s, p;
        startTurn(5'd12, s);
        p = s + 2;
        expQ.push_back('{1'b1, p, 4});
`ifdef BJ_AUTOPLAY_TIMEOUT_EN
        waitUntil(p + 71);
        nChecks++;
        if (obs !== 10'b11_1000_0001) $display("FAIL tmo_before: got %b, required 1110000001", obs);
        else nPass++;
        waitUntil(p + 72);
        nChecks++;
        if (obs !== 10'b11_0101_0001) $display("FAIL tmo_expired: got %b, required 1101010001", obs);
        else nPass++;
`else
        waitUntil(p + 8 + 1000);
        nChecks++;
        if (obs !== 10'b11_1000_0001) $display("FAIL tmo_disabled_wait: got %b, required 1110000001", obs);
        else nPass++;
`endif
        endTurn();
    endtask

    initial begin
        bus.i_Enable     = 1'b0;
        bus.i_TurnActive = 1'b0;
        bus.i_Ready      = 1'b0;
        bus.i_HandTotal  = 5'd0;
        test_reset();
        test_hit_then_stay();
        test_stay_threshold();
        test_hit_below();
        test_bust();
        test_enable_drop();
        test_reset_mid_press();
        test_back_to_back_max_hits();
        test_timeout();
        repeat (2) @(negedge clk);
        nChecks++;
        if (expQ.size() != 0) $display("FAIL presses_missing: %0d outstanding, required 0", expQ.size());
        else nPass++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
